instr_issue_sequencer: RTL and testbench
========================================

Name: instr_issue_sequencer

Overview:
- Drives the processor core's 16-bit instruction input from the host side of the same interface.
- Host writes 11-bit instructions into an internal FIFO.
- The sequencer presents one instruction at a time, zero-padded to 16 bits, and holds it stable until the core pulses Done.
- A NOP gap follows each instruction, then the sequencer advances. It sits between host/testbench and the core.

Parameters:
- REG_WIDTH, 16, width of the padded instruction word driven to the core.
- INSTRUCTION_SIZE, 11, width of one instruction.
- FIFO_DEPTH, 8, instruction buffer entries; power of two, at least 2.
- NOP_CODE, 0, 11-bit value driven when no instruction is active.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  host write strobe, one instruction per cycle.
- wr_instr  in  INSTRUCTION_SIZE  instruction to enqueue.
- Done  in  1  one-cycle pulse from the core's control circuit at instruction completion.
- INSTRUCTION_with_padding  out  REG_WIDTH  {zeros, current instruction}, or NOP_CODE when idle.
- instr_valid  out  1  high while an instruction is held awaiting Done.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- fifo_count  out  log2(FIFO_DEPTH)+1  entries stored.
- busy  out  1  high whenever the FSM is not IDLE.
- issued_count  out  16  instructions completed; wraps 0xFFFF -> 0.
- overflow  out  1  sticky: a write was dropped.

Behaviour:
- Reset (reset=0, async):
  - FSM=IDLE, FIFO emptied, empty=1, full=0, fifo_count=0.
  - INSTRUCTION_with_padding = NOP_CODE zero-extended.
  - instr_valid=0, busy=0, issued_count=0, overflow=0.
  - Reset mid-instruction abandons the held instruction; it is not counted.
- FIFO:
  - Write accepted when wr_en && (!full || pop in the same cycle).
  - wr_en && full with no pop: data dropped, overflow set; it is cleared only by reset.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - full/empty/fifo_count are registered, and are valid in the cycle after the write.
- FSM states: IDLE, LOAD, HOLD, GAP.
  - IDLE: output = NOP. If !empty: pop the head into cur_instr, go to LOAD.
  - LOAD: drive cur_instr on the output, instr_valid=1, go to HOLD. Done in LOAD is treated as in HOLD.
  - HOLD: output and instr_valid held stable. On Done=1: issued_count+1, instr_valid=0, go to GAP.
  - GAP: output = NOP for exactly one cycle, so back-to-back identical instructions produce an observable change. Then go to IDLE.
- Latency:
  - A write into an empty FIFO with the FSM in IDLE at edge t appears on the output after edge t+2.
  - Back-to-back instructions: Done at edge d; the next instruction appears after edge d+3.
- Done asserted in IDLE or GAP is ignored: no count, no state change.
- A Done pulse longer than one cycle completes only the held instruction; the extra cycles fall in GAP and are ignored.
- Padding: bits [REG_WIDTH-1:INSTRUCTION_SIZE] are always 0.

Optional Feature:
- Macro: ISSUE_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYCLES (default 255) and output timeout (1 bit, sticky until reset).
  - A 16-bit counter clears on entering HOLD and increments each HOLD cycle.
  - When it reaches TIMEOUT_CYCLES without Done: timeout=1, instruction dropped (not counted), FSM goes to GAP.
- When undefined: no counter, no port, HOLD waits forever.

Decomposition:
- Shared package holds:
  - constants REG_WIDTH=16, INSTRUCTION_SIZE=11, NOP_CODE;
  - 2-bit FSM state encoding (IDLE=0, LOAD=1, HOLD=2, GAP=3).
- One sub-module: instr_fifo (parameterised synchronous FIFO with count/full/empty, async active-low reset).
- The FSM, counter and timeout stay in the top module.

Test Plan:
- Reset, then write 0x123 at cycle 1 -> output 0x0123 and instr_valid=1 from cycle 3. Hold 10 cycles, pulse Done -> issued_count=1, output 0x0000 for one cycle, then busy=0.
- Write 0x7FF, 0x7FF, 0x001 back-to-back, Done 5 cycles after each appears -> output sequence 0x07FF, NOP, 0x07FF, NOP, 0x0001. issued_count=3, with no bits above bit 10 ever set.
- Nine writes with Done held low (DEPTH=8) -> first pops into LOAD, 8 remain stored, full=1. Then write 0x055 while full -> overflow=1 and fifo_count stays 8. Next, a push coinciding with a pop is accepted.
- Done pulses while IDLE and while in GAP -> issued_count unchanged, FSM unaffected.
- Assert reset while HOLD has 0x2AA and the FIFO holds 3 entries -> all outputs return to reset values immediately, without waiting for a clock edge. issued_count=0.
- ISSUE_TIMEOUT_EN defined, TIMEOUT_CYCLES=20: no Done for 20 cycles -> timeout=1, issued_count unchanged, next instruction issues.

Source files
------------

// File: rtl/instr_issue_sequencer_pkg.sv
// Shared constants, FSM encoding and padding helper for the instruction issue sequencer.
// Purpose: single source of truth for instruction/word widths and the idle (NOP) code.
package instr_issue_sequencer_pkg;

    localparam int unsigned REG_WIDTH        = 16;
    localparam int unsigned INSTRUCTION_SIZE = 11;
    localparam int unsigned ISSUED_W         = 16;
    localparam int unsigned TO_CNT_W         = 16;

    localparam logic [INSTRUCTION_SIZE-1:0] NOP_CODE = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_t;

    // Zero-extend an instruction to the core's register width.
    function automatic logic [REG_WIDTH-1:0] pad_instr(input logic [INSTRUCTION_SIZE-1:0] instr);
        return REG_WIDTH'(instr);
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered count/full/empty and a sticky overflow flag.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_data : write strobe and data; accepted when not full or when popping
//   pop             : read strobe; ignored while empty
//   rd_data_c       : head entry (combinational)
//   full, empty     : registered status
//   count           : registered number of stored entries
//   overflow        : sticky, set when a write was dropped
module instr_fifo #(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [DATA_WIDTH-1:0]     push_data,
    input  logic                      pop,
    output logic [DATA_WIDTH-1:0]     rd_data_c,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push_ok_c;
    logic                  pop_ok_c;
    logic [CNT_W-1:0]      count_next_c;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    always_comb begin
        pop_ok_c     = pop && !empty;
        push_ok_c    = push && (!full || pop_ok_c);
        count_next_c = count + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        rd_data_c    = mem[rd_ptr];
    end

    // Storage array; no reset needed, validity tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
            empty <= (count_next_c == '0);
            if (push && !push_ok_c) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_issue_sequencer.sv
// Instruction issue sequencer: buffers host instructions and presents them one at a
// time, zero-padded, to the core until it pulses Done, with a NOP gap between issues.
// Optional feature macro: ISSUE_TIMEOUT_EN (adds TIMEOUT_CYCLES and the timeout output).
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   wr_en, wr_instr           : host enqueue strobe and instruction
//   Done                      : core completion pulse
//   INSTRUCTION_with_padding  : padded current instruction, or NOP when idle
//   instr_valid               : instruction held awaiting Done
//   full, empty, fifo_count   : buffer status
//   busy                      : FSM not idle
//   issued_count              : completed instructions (wrapping)
//   overflow                  : sticky dropped-write flag
//   timeout                   : sticky Done-timeout flag (ISSUE_TIMEOUT_EN only)
module instr_issue_sequencer
    import instr_issue_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
`ifdef ISSUE_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [INSTRUCTION_SIZE-1:0]   wr_instr,
    input  logic                          Done,
    output logic [REG_WIDTH-1:0]          INSTRUCTION_with_padding,
    output logic                          instr_valid,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic [ISSUED_W-1:0]           issued_count,
    output logic                          overflow
`ifdef ISSUE_TIMEOUT_EN
    , output logic                        timeout
`endif
);

    seq_state_t                  state;
    seq_state_t                  state_next;
    logic [INSTRUCTION_SIZE-1:0] cur_instr;
    logic [INSTRUCTION_SIZE-1:0] fifo_head_c;
    logic                        pop_c;
    logic                        timeout_hit_c;

    logic [REG_WIDTH-1:0]        out_d;
    logic                        valid_d;
    logic [ISSUED_W-1:0]         issued_d;

`ifdef ISSUE_TIMEOUT_EN
    logic [TO_CNT_W-1:0]         to_cnt;
    logic [TO_CNT_W-1:0]         to_cnt_d;
    logic                        timeout_d;

    // HOLD has lasted TIMEOUT_CYCLES cycles with no Done.
    assign timeout_hit_c = (state == ST_HOLD) && !Done &&
                           ((to_cnt + TO_CNT_W'(1)) >= TO_CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit_c = 1'b0;
`endif

    assign pop_c = (state == ST_IDLE) && !empty;

    instr_fifo #(
        .DATA_WIDTH (INSTRUCTION_SIZE),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (wr_en),
        .push_data (wr_instr),
        .pop       (pop_c),
        .rd_data_c (fifo_head_c),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .overflow  (overflow)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; Done in LOAD completes exactly as in HOLD.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!empty) state_next = ST_LOAD;
            ST_LOAD: state_next = Done ? ST_GAP : ST_HOLD;
            ST_HOLD: if (Done || timeout_hit_c) state_next = ST_GAP;
            ST_GAP:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    always_comb begin
        out_d    = INSTRUCTION_with_padding;
        valid_d  = instr_valid;
        issued_d = issued_count;
`ifdef ISSUE_TIMEOUT_EN
        to_cnt_d  = to_cnt;
        timeout_d = timeout;
`endif
        case (state)
            ST_IDLE: begin
                out_d   = pad_instr(NOP_CODE);
                valid_d = 1'b0;
            end
            ST_LOAD: begin
`ifdef ISSUE_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (Done) begin
                    out_d    = pad_instr(NOP_CODE);
                    valid_d  = 1'b0;
                    issued_d = issued_count + ISSUED_W'(1);
                end else begin
                    out_d   = pad_instr(cur_instr);
                    valid_d = 1'b1;
                end
            end
            ST_HOLD: begin
`ifdef ISSUE_TIMEOUT_EN
                to_cnt_d = to_cnt + TO_CNT_W'(1);
`endif
                if (Done) begin
                    out_d    = pad_instr(NOP_CODE);
                    valid_d  = 1'b0;
                    issued_d = issued_count + ISSUED_W'(1);
                end else if (timeout_hit_c) begin
                    out_d   = pad_instr(NOP_CODE);
                    valid_d = 1'b0;
`ifdef ISSUE_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            ST_GAP: begin
                out_d   = pad_instr(NOP_CODE);
                valid_d = 1'b0;
            end
            default: begin
                out_d   = pad_instr(NOP_CODE);
                valid_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            INSTRUCTION_with_padding <= pad_instr(NOP_CODE);
            instr_valid              <= 1'b0;
            busy                     <= 1'b0;
            issued_count             <= '0;
            cur_instr                <= NOP_CODE;
`ifdef ISSUE_TIMEOUT_EN
            to_cnt                   <= '0;
            timeout                  <= 1'b0;
`endif
        end else begin
            INSTRUCTION_with_padding <= out_d;
            instr_valid              <= valid_d;
            busy                     <= (state_next != ST_IDLE);
            issued_count             <= issued_d;
            if (pop_c) cur_instr <= fifo_head_c;
`ifdef ISSUE_TIMEOUT_EN
            to_cnt                   <= to_cnt_d;
            timeout                  <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Directed testbench for instr_issue_sequencer.
module tb_instr_issue_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [10:0] wr_instr;
    logic        Done;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        full;
    logic        empty;
    logic [3:0]  fifo_count;
    logic        busy;
    logic [15:0] issued_count;
    logic        overflow;
`ifdef ISSUE_TIMEOUT_EN
    logic        timeout;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    instr_issue_sequencer #(
        .FIFO_DEPTH (8)
`ifdef ISSUE_TIMEOUT_EN
        , .TIMEOUT_CYCLES (20)
`endif
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .wr_en                    (wr_en),
        .wr_instr                 (wr_instr),
        .Done                     (Done),
        .INSTRUCTION_with_padding (instr_out),
        .instr_valid              (instr_valid),
        .full                     (full),
        .empty                    (empty),
        .fifo_count               (fifo_count),
        .busy                     (busy),
        .issued_count             (issued_count),
        .overflow                 (overflow)
`ifdef ISSUE_TIMEOUT_EN
        , .timeout                (timeout)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_one(input logic [10:0] val);
        wr_en    = 1'b1;
        wr_instr = val;
        step();
        wr_en    = 1'b0;
    endtask

    // Bounded wait for an instruction to be presented.
    task automatic wait_valid(input string tag);
        for (int n = 0; n < 20 && !instr_valid; n++) step();
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    // Wait for the next instruction, check it, and complete it with a one-cycle Done.
    task automatic complete(input string tag, input logic [15:0] exp);
        wait_valid(tag);
        chk(tag, 32'(instr_out), 32'(exp));
        Done = 1'b1;
        step();
        Done = 1'b0;
        chk({tag, "_done"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},    32'(instr_out),    32'h0);
        chk({tag, "_valid"},  32'(instr_valid),  32'd0);
        chk({tag, "_full"},   32'(full),         32'd0);
        chk({tag, "_empty"},  32'(empty),        32'd1);
        chk({tag, "_count"},  32'(fifo_count),   32'd0);
        chk({tag, "_busy"},   32'(busy),         32'd0);
        chk({tag, "_issued"}, 32'(issued_count), 32'd0);
        chk({tag, "_ovf"},    32'(overflow),     32'd0);
`ifdef ISSUE_TIMEOUT_EN
        chk({tag, "_tmo"},    32'(timeout),      32'd0);
`endif
    endtask

    initial begin
        logic [10:0] seq [3];
        seq[0] = 11'h7FF;
        seq[1] = 11'h7FF;
        seq[2] = 11'h001;

        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_instr = '0;
        Done     = 1'b0;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b1;

        // Single instruction: write at edge 1, visible after edge 3.
        write_one(11'h123);
        chk("t1_empty", 32'(empty), 32'd0);
        chk("t1_count", 32'(fifo_count), 32'd1);
        chk("t1_out_e1", 32'(instr_out), 32'h0);
        step();
        chk("t1_busy_e2", 32'(busy), 32'd1);
        chk("t1_out_e2", 32'(instr_out), 32'h0);
        chk("t1_count_e2", 32'(fifo_count), 32'd0);
        step();
        chk("t1_out_e3", 32'(instr_out), 32'h0123);
        chk("t1_valid_e3", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t1_hold", 32'(instr_out), 32'h0123);
        end
        Done = 1'b1;
        step();
        Done = 1'b0;
        chk("t1_issued", 32'(issued_count), 32'd1);
        chk("t1_gap_out", 32'(instr_out), 32'h0);
        chk("t1_gap_valid", 32'(instr_valid), 32'd0);
        chk("t1_gap_busy", 32'(busy), 32'd1);
        step();
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // Back-to-back instructions with exact d+3 reissue latency.
        for (int i = 0; i < 3; i++) begin
            wr_en    = 1'b1;
            wr_instr = seq[i];
            step();
        end
        wr_en = 1'b0;
        wait_valid("t2_first");
        for (int k = 0; k < 3; k++) begin
            chk("t2_out", 32'(instr_out), 32'(seq[k]));
            chk("t2_pad", 32'(instr_out[15:11]), 32'd0);
            repeat (4) step();
            Done = 1'b1;
            step();
            Done = 1'b0;
            chk("t2_nop_d0", 32'(instr_out), 32'h0);
            chk("t2_inv_d0", 32'(instr_valid), 32'd0);
            step();
            chk("t2_nop_d1", 32'(instr_out), 32'h0);
            if (k < 2) begin
                step();
                chk("t2_nop_d2", 32'(instr_out), 32'h0);
                step();
                chk("t2_valid_d3", 32'(instr_valid), 32'd1);
            end else begin
                chk("t2_busy_end", 32'(busy), 32'd0);
            end
        end
        chk("t2_issued", 32'(issued_count), 32'd4);

        // Fill: nine writes, first one issued, eight buffered.
        for (int i = 0; i < 9; i++) begin
            wr_en    = 1'b1;
            wr_instr = 11'(257 + i);
            step();
        end
        wr_en = 1'b0;
        chk("t3_count8", 32'(fifo_count), 32'd8);
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_no_ovf", 32'(overflow), 32'd0);
        chk("t3_head_out", 32'(instr_out), 32'h0101);
        write_one(11'h055);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_ovf_count", 32'(fifo_count), 32'd8);
        chk("t3_ovf_full", 32'(full), 32'd1);
        Done = 1'b1;
        step();
        Done = 1'b0;
        step();
        wr_en    = 1'b1;
        wr_instr = 11'h066;
        step();
        wr_en = 1'b0;
        chk("t3_pushpop_count", 32'(fifo_count), 32'd8);
        chk("t3_pushpop_full", 32'(full), 32'd1);
        chk("t3_issued5", 32'(issued_count), 32'd5);
        for (int i = 1; i < 9; i++) complete("t3_drain", 16'(257 + i));
        complete("t3_drain_last", 16'h0066);
        chk("t3_empty", 32'(empty), 32'd1);
        chk("t3_issued14", 32'(issued_count), 32'd14);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Done while IDLE, and Done stretched into GAP.
        step();
        step();
        Done = 1'b1;
        step();
        Done = 1'b0;
        chk("t4_idle_issued", 32'(issued_count), 32'd14);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_valid", 32'(instr_valid), 32'd0);
        write_one(11'h3C3);
        wait_valid("t4_wait");
        chk("t4_out", 32'(instr_out), 32'h03C3);
        Done = 1'b1;
        step();
        chk("t4_issued_d0", 32'(issued_count), 32'd15);
        step();
        Done = 1'b0;
        chk("t4_gap_issued", 32'(issued_count), 32'd15);
        chk("t4_gap_busy", 32'(busy), 32'd0);
        step();
        chk("t4_after_out", 32'(instr_out), 32'h0);

        // Asynchronous reset while HOLD has 0x2AA and three entries are buffered.
        write_one(11'h2AA);
        write_one(11'h011);
        write_one(11'h022);
        write_one(11'h033);
        chk("t5_out", 32'(instr_out), 32'h02AA);
        chk("t5_valid", 32'(instr_valid), 32'd1);
        chk("t5_count", 32'(fifo_count), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        step();
        reset = 1'b1;
        step();
        chk("t5_post_out", 32'(instr_out), 32'h0);
        chk("t5_post_busy", 32'(busy), 32'd0);

`ifdef ISSUE_TIMEOUT_EN
        // No Done for 20 HOLD cycles drops the instruction, then the next issues.
        write_one(11'h0AB);
        write_one(11'h0CD);
        wait_valid("t6_wait");
        chk("t6_out", 32'(instr_out), 32'h00AB);
        repeat (19) step();
        chk("t6_pre_tmo", 32'(timeout), 32'd0);
        chk("t6_pre_valid", 32'(instr_valid), 32'd1);
        step();
        chk("t6_tmo", 32'(timeout), 32'd1);
        chk("t6_tmo_valid", 32'(instr_valid), 32'd0);
        chk("t6_tmo_issued", 32'(issued_count), 32'd0);
        complete("t6_next", 16'h00CD);
        chk("t6_issued", 32'(issued_count), 32'd1);
        chk("t6_tmo_sticky", 32'(timeout), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
